// File: rtl/cpu.sv
// cpu: five-stage pipelined MIPS-subset core (IF, ID, EX, MEM, WB) with
// on-chip instruction memory, data memory and register file.
// EX-stage forwarding, load-use stall, branches/jumps resolved in ID.
// Optional feature macro: CPU_MUL_EN (adds the mul instruction).
module cpu (
    input logic clk_i,
    input logic rst_i,
    input logic start_i
);
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
`ifdef CPU_MUL_EN
    localparam logic [5:0] FN_MUL   = 6'h18;
`endif

    typedef enum logic [2:0] {ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_MUL} alu_op_t;

    typedef struct packed {
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    mem_to_reg;
        logic    alu_src;
        alu_op_t alu_op;
    } ctrl_t;

    // IF/ID
    logic [31:0] ifid_instr, ifid_pc4;
    // ID/EX
    ctrl_t       idex_ctrl;
    logic [31:0] idex_a, idex_b, idex_imm;
    logic [4:0]  idex_rs, idex_rt, idex_dst;
    // EX/MEM
    logic        exmem_reg_write, exmem_mem_write, exmem_mem_to_reg;
    logic [31:0] exmem_alu, exmem_store;
    logic [4:0]  exmem_dst;
    // MEM/WB
    logic        memwb_reg_write, memwb_mem_to_reg;
    logic [31:0] memwb_alu, memwb_load;
    logic [4:0]  memwb_dst;

    logic [31:0] wb_data, pc_plus4, pc_next, instr_if;
    logic [31:0] rd1, rd2, imm_ext, branch_target, jump_target;
    logic [31:0] fwd_a, fwd_b, alu_b, alu_y, load_word;
    logic [5:0]  op, funct;
    logic [4:0]  rs, rt, rd, id_dst, mem_base;
    ctrl_t       id_ctrl;
    logic        is_beq, is_j, stall, take_beq, take_j, flush;

    if (1'b1) begin : PC
        logic [31:0] pc_o;
        // Program counter: holds on stall or when not started.
        always_ff @(posedge clk_i or negedge rst_i) begin
            if (!rst_i) pc_o <= '0;
            else if (start_i && !stall) pc_o <= pc_next;
        end
    end

    if (1'b1) begin : Instruction_Memory
        logic [31:0] memory [0:255];
        // Contents are preloaded from outside; the core never writes them.
        always_ff @(posedge clk_i) memory <= memory;
    end

    if (1'b1) begin : Data_Memory
        logic [7:0] memory [0:31];
        // Little-endian aligned word store from the MEM stage.
        always_ff @(posedge clk_i) begin
            if (exmem_mem_write) begin
                memory[mem_base]        <= exmem_store[7:0];
                memory[mem_base + 5'd1] <= exmem_store[15:8];
                memory[mem_base + 5'd2] <= exmem_store[23:16];
                memory[mem_base + 5'd3] <= exmem_store[31:24];
            end
        end
    end

    if (1'b1) begin : Registers
        logic [31:0] register [0:31];
        // Write-back port; register 0 is never written.
        always_ff @(posedge clk_i) begin
            if (memwb_reg_write && memwb_dst != '0) register[memwb_dst] <= wb_data;
        end
    end

    assign instr_if  = Instruction_Memory.memory[PC.pc_o[9:2]];
    assign pc_plus4  = PC.pc_o + 32'd4;
    assign op        = ifid_instr[31:26];
    assign rs        = ifid_instr[25:21];
    assign rt        = ifid_instr[20:16];
    assign rd        = ifid_instr[15:11];
    assign funct     = ifid_instr[5:0];
    assign imm_ext   = {{16{ifid_instr[15]}}, ifid_instr[15:0]};
    assign wb_data   = memwb_mem_to_reg ? memwb_load : memwb_alu;
    assign mem_base  = {exmem_alu[4:2], 2'b00};
    assign load_word = {Data_Memory.memory[mem_base + 5'd3], Data_Memory.memory[mem_base + 5'd2],
                        Data_Memory.memory[mem_base + 5'd1], Data_Memory.memory[mem_base]};

    // Decode of the ID instruction into control; unknown encodings stay nop.
    always_comb begin
        id_ctrl = '0;
        id_dst  = rt;
        is_beq  = 1'b0;
        is_j    = 1'b0;
        case (op)
            OP_RTYPE: begin
                id_dst = rd;
                case (funct)
                    FN_ADD: id_ctrl.reg_write = 1'b1;
                    FN_SUB: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_SUB; end
                    FN_AND: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_AND; end
                    FN_OR:  begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_OR;  end
`ifdef CPU_MUL_EN
                    FN_MUL: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_op = ALU_MUL; end
`endif
                    default: ;
                endcase
            end
            OP_ADDI: begin id_ctrl.reg_write = 1'b1; id_ctrl.alu_src = 1'b1; end
            OP_LW: begin
                id_ctrl.reg_write  = 1'b1;
                id_ctrl.mem_read   = 1'b1;
                id_ctrl.mem_to_reg = 1'b1;
                id_ctrl.alu_src    = 1'b1;
            end
            OP_SW:  begin id_ctrl.mem_write = 1'b1; id_ctrl.alu_src = 1'b1; end
            OP_BEQ: is_beq = 1'b1;
            OP_J:   is_j = 1'b1;
            default: ;
        endcase
    end

    // Register-file reads with same-cycle write-back bypass; $0 reads zero.
    always_comb begin
        rd1 = Registers.register[rs];
        rd2 = Registers.register[rt];
        if (rs == '0) rd1 = '0;
        else if (memwb_reg_write && memwb_dst == rs) rd1 = wb_data;
        if (rt == '0) rd2 = '0;
        else if (memwb_reg_write && memwb_dst == rt) rd2 = wb_data;
    end

    // Hazard detection and control-flow resolution; a stall suppresses redirects.
    always_comb begin
        stall         = idex_ctrl.mem_read && (idex_rt == rs || idex_rt == rt);
        take_beq      = is_beq && (rd1 == rd2) && !stall;
        take_j        = is_j && !stall;
        flush         = take_beq || take_j;
        branch_target = ifid_pc4 + {imm_ext[29:0], 2'b00};
        jump_target   = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00};
        pc_next       = pc_plus4;
        if (take_beq) pc_next = branch_target;
        else if (take_j) pc_next = jump_target;
    end

    // IF/ID: holds on stall, nop on flush or while not started so the pipe drains.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            ifid_instr <= '0;
            ifid_pc4   <= '0;
        end else if (!stall) begin
            ifid_instr <= (flush || !start_i) ? '0 : instr_if;
            ifid_pc4   <= pc_plus4;
        end
    end

    // ID/EX: a stall injects a bubble with all control cleared.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            idex_ctrl <= '0;
            idex_a    <= '0;
            idex_b    <= '0;
            idex_imm  <= '0;
            idex_rs   <= '0;
            idex_rt   <= '0;
            idex_dst  <= '0;
        end else begin
            if (stall) idex_ctrl <= '0;
            else       idex_ctrl <= id_ctrl;
            idex_a   <= rd1;
            idex_b   <= rd2;
            idex_imm <= imm_ext;
            idex_rs  <= rs;
            idex_rt  <= rt;
            idex_dst <= id_dst;
        end
    end

    // Operand forwarding: EX/MEM has priority over MEM/WB.
    always_comb begin
        fwd_a = idex_a;
        fwd_b = idex_b;
        if (exmem_reg_write && exmem_dst != '0 && exmem_dst == idex_rs) fwd_a = exmem_alu;
        else if (memwb_reg_write && memwb_dst != '0 && memwb_dst == idex_rs) fwd_a = wb_data;
        if (exmem_reg_write && exmem_dst != '0 && exmem_dst == idex_rt) fwd_b = exmem_alu;
        else if (memwb_reg_write && memwb_dst != '0 && memwb_dst == idex_rt) fwd_b = wb_data;
        alu_b = idex_ctrl.alu_src ? idex_imm : fwd_b;
    end

    // EX-stage ALU.
    always_comb begin
        alu_y = fwd_a + alu_b;
        case (idex_ctrl.alu_op)
            ALU_SUB: alu_y = fwd_a - alu_b;
            ALU_AND: alu_y = fwd_a & alu_b;
            ALU_OR:  alu_y = fwd_a | alu_b;
`ifdef CPU_MUL_EN
            ALU_MUL: alu_y = fwd_a * alu_b;
`endif
            default: ;
        endcase
    end

    // EX/MEM and MEM/WB pipeline registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            exmem_reg_write  <= 1'b0;
            exmem_mem_write  <= 1'b0;
            exmem_mem_to_reg <= 1'b0;
            exmem_alu        <= '0;
            exmem_store      <= '0;
            exmem_dst        <= '0;
            memwb_reg_write  <= 1'b0;
            memwb_mem_to_reg <= 1'b0;
            memwb_alu        <= '0;
            memwb_load       <= '0;
            memwb_dst        <= '0;
        end else begin
            exmem_reg_write  <= idex_ctrl.reg_write;
            exmem_mem_write  <= idex_ctrl.mem_write;
            exmem_mem_to_reg <= idex_ctrl.mem_to_reg;
            exmem_alu        <= alu_y;
            exmem_store      <= fwd_b;
            exmem_dst        <= idex_dst;
            memwb_reg_write  <= exmem_reg_write;
            memwb_mem_to_reg <= exmem_mem_to_reg;
            memwb_alu        <= exmem_alu;
            memwb_load       <= load_word;
            memwb_dst        <= exmem_dst;
        end
    end
endmodule

// File: tb/tb_cpu.sv
// tb_cpu: directed programs against an instruction-level model of the core.
module tb_cpu;
    logic clk, rst, start;
    initial clk = 1'b0;
    always #5 clk = ~clk;

    cpu dut (.clk_i(clk), .rst_i(rst), .start_i(start));

    int tests = 0;
    int fails = 0;

    // Architectural model: each instruction takes effect as it leaves ID.
    logic [31:0] m_reg  [32];
    logic [7:0]  m_dmem [32];
    logic [31:0] m_imem [256];
    logic [31:0] m_pc, m_id, m_id_pc4;
    logic        m_ex_lw;
    logic [4:0]  m_ex_rt;
    int          m_stalls, m_flushes;

    logic        mon_en, have_prev, prev_start;
    logic [31:0] prev_pc;
    int          dut_holds, dut_jumps;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
        return {6'h00, rs, rt, rd, 5'd0, fn};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic logic [31:0] enc_j(input logic [25:0] t);
        return {6'h02, t};
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] addr);
        logic [4:0] b;
        b = {addr[4:2], 2'b00};
        return {m_dmem[b + 5'd3], m_dmem[b + 5'd2], m_dmem[b + 5'd1], m_dmem[b]};
    endfunction

    task automatic m_store(input logic [31:0] addr, input logic [31:0] v);
        logic [4:0] b;
        b = {addr[4:2], 2'b00};
        m_dmem[b]        = v[7:0];
        m_dmem[b + 5'd1] = v[15:8];
        m_dmem[b + 5'd2] = v[23:16];
        m_dmem[b + 5'd3] = v[31:24];
    endtask

    task automatic m_wr(input logic [4:0] d, input logic [31:0] v);
        if (d != 5'd0) m_reg[d] = v;
    endtask

    // One clock of the model: what happens to PC and the ID slot at the next edge.
    task automatic model_step();
        logic [5:0]  op, fn;
        logic [4:0]  rs, rt, rd;
        logic [31:0] a, b, sx, target;
        logic        redirect;
        op = m_id[31:26]; rs = m_id[25:21]; rt = m_id[20:16]; rd = m_id[15:11]; fn = m_id[5:0];
        if (m_ex_lw && (rs == m_ex_rt || rt == m_ex_rt)) begin
            m_ex_lw = 1'b0;
            m_stalls++;
            return;
        end
        a = m_reg[rs]; b = m_reg[rt];
        sx = {{16{m_id[15]}}, m_id[15:0]};
        redirect = 1'b0; target = '0;
        case (op)
            6'h00: case (fn)
                6'h20: m_wr(rd, a + b);
                6'h22: m_wr(rd, a - b);
                6'h24: m_wr(rd, a & b);
                6'h25: m_wr(rd, a | b);
`ifdef CPU_MUL_EN
                6'h18: m_wr(rd, a * b);
`endif
                default: ;
            endcase
            6'h08: m_wr(rt, a + sx);
            6'h23: m_wr(rt, m_load(a + sx));
            6'h2B: m_store(a + sx, b);
            6'h04: if (a == b) begin redirect = 1'b1; target = m_id_pc4 + (sx << 2); end
            6'h02: begin redirect = 1'b1; target = {m_id_pc4[31:28], m_id[25:0], 2'b00}; end
            default: ;
        endcase
        m_ex_lw = (op == 6'h23);
        m_ex_rt = rt;
        if (!start) begin
            m_id = '0;
        end else if (redirect) begin
            m_pc = target; m_id = '0; m_flushes++;
        end else begin
            m_id = m_imem[m_pc[9:2]]; m_id_pc4 = m_pc + 32'd4; m_pc = m_pc + 32'd4;
        end
    endtask

    // Per-cycle comparison of the PC against the model, plus hold/jump counters.
    always @(negedge clk) begin
        if (mon_en) begin
            check("pc", dut.PC.pc_o, m_pc);
            if (have_prev) begin
                if (prev_start && dut.PC.pc_o == prev_pc) dut_holds++;
                if (dut.PC.pc_o != prev_pc && dut.PC.pc_o != prev_pc + 32'd4) dut_jumps++;
            end
            have_prev = 1'b1; prev_pc = dut.PC.pc_o; prev_start = start;
            model_step();
        end
    end

    task automatic clear_model();
        for (int i = 0; i < 32; i++) begin m_reg[i] = '0; m_dmem[i] = '0; end
        for (int i = 0; i < 256; i++) m_imem[i] = '0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic start_run();
        mon_en = 1'b0; rst = 1'b0; start = 1'b0;
        #1;
        check("reset_pc", dut.PC.pc_o, 32'd0);
        for (int i = 0; i < 256; i++) dut.Instruction_Memory.memory[i] = m_imem[i];
        for (int i = 0; i < 32; i++) begin
            dut.Data_Memory.memory[i] = m_dmem[i];
            dut.Registers.register[i] = m_reg[i];
        end
        m_pc = '0; m_id = '0; m_id_pc4 = '0; m_ex_lw = 1'b0; m_ex_rt = '0;
        m_stalls = 0; m_flushes = 0; have_prev = 1'b0; prev_start = 1'b0;
        dut_holds = 0; dut_jumps = 0;
        @(posedge clk); #2;
        rst = 1'b1; start = 1'b1; mon_en = 1'b1;
    endtask

    task automatic finish_run(input string tag);
        start = 1'b0;
        run_cycles(6);
        mon_en = 1'b0;
        for (int i = 1; i < 32; i++)
            check($sformatf("%s_r%0d", tag, i), dut.Registers.register[i], m_reg[i]);
        for (int w = 0; w < 8; w++)
            check($sformatf("%s_mem%0d", tag, w),
                  {dut.Data_Memory.memory[4*w+3], dut.Data_Memory.memory[4*w+2],
                   dut.Data_Memory.memory[4*w+1], dut.Data_Memory.memory[4*w]},
                  {m_dmem[4*w+3], m_dmem[4*w+2], m_dmem[4*w+1], m_dmem[4*w]});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b0; start = 1'b0; mon_en = 1'b0;
        @(posedge clk); #2;

        // Reset/start with an all-zero program: PC counts, nothing changes.
        clear_model();
        for (int i = 1; i < 32; i++) m_reg[i] = 32'(i * 17);
        start_run();
        run_cycles(8);
        check("t0_pc_after8", dut.PC.pc_o, 32'd32);
        check("t0_holds", 32'(dut_holds), 32'd0);
        finish_run("t0");
        check("t0_pc_held", dut.PC.pc_o, 32'd32);
        check("t0_r5", dut.Registers.register[5], 32'd85);

        // Forwarding chain.
        clear_model();
        m_imem[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
        m_imem[1] = enc_i(6'h08, 5'd8, 5'd9, 16'd3);
        m_imem[2] = enc_r(5'd9, 5'd8, 5'd10, 6'h20);
        start_run();
        run_cycles(10);
        finish_run("t1");
        check("t1_r8", dut.Registers.register[8], 32'd5);
        check("t1_r9", dut.Registers.register[9], 32'd8);
        check("t1_r10", dut.Registers.register[10], 32'd13);
        check("t1_holds", 32'(dut_holds), 32'd0);

        // Load-use stall.
        clear_model();
        m_dmem[0] = 8'd5;
        m_imem[0] = enc_i(6'h23, 5'd0, 5'd8, 16'd0);
        m_imem[1] = enc_r(5'd8, 5'd8, 5'd9, 6'h20);
        start_run();
        run_cycles(12);
        finish_run("t2");
        check("t2_r9", dut.Registers.register[9], 32'd10);
        check("t2_holds", 32'(dut_holds), 32'd1);
        check("t2_model_stalls", 32'(m_stalls), 32'd1);

        // Multiply then store through EX/MEM forwarding.
        clear_model();
        m_imem[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd6);
        m_imem[1] = enc_i(6'h08, 5'd0, 5'd9, 16'd7);
        m_imem[2] = enc_r(5'd8, 5'd9, 5'd10, 6'h18);
        m_imem[3] = enc_i(6'h2B, 5'd0, 5'd10, 16'd4);
        start_run();
        run_cycles(12);
        finish_run("t3");
`ifdef CPU_MUL_EN
        check("t3_word4", {dut.Data_Memory.memory[7], dut.Data_Memory.memory[6],
                           dut.Data_Memory.memory[5], dut.Data_Memory.memory[4]}, 32'd42);
        check("t3_r10", dut.Registers.register[10], 32'd42);
`else
        check("t3_word4", {dut.Data_Memory.memory[7], dut.Data_Memory.memory[6],
                           dut.Data_Memory.memory[5], dut.Data_Memory.memory[4]}, 32'd0);
        check("t3_r10", dut.Registers.register[10], 32'd0);
`endif

        // Taken beq flushes its successor; a later not-taken beq falls through.
        clear_model();
        m_imem[0] = enc_i(6'h04, 5'd0, 5'd0, 16'd1);
        m_imem[1] = enc_i(6'h08, 5'd0, 5'd11, 16'd1);
        m_imem[2] = enc_i(6'h08, 5'd0, 5'd12, 16'd2);
        m_imem[5] = enc_i(6'h04, 5'd12, 5'd0, 16'd5);
        m_imem[6] = enc_i(6'h08, 5'd0, 5'd13, 16'd3);
        start_run();
        run_cycles(14);
        finish_run("t4");
        check("t4_r11", dut.Registers.register[11], 32'd0);
        check("t4_r12", dut.Registers.register[12], 32'd2);
        check("t4_r13", dut.Registers.register[13], 32'd3);
        check("t4_model_flushes", 32'(m_flushes), 32'd1);

        // Jump loop: three-cycle iterations, slot after j always flushed.
        clear_model();
        m_imem[0] = enc_i(6'h08, 5'd8, 5'd8, 16'd1);
        m_imem[1] = enc_j(26'd0);
        m_imem[2] = enc_i(6'h08, 5'd0, 5'd9, 16'd7);
        start_run();
        run_cycles(12);
        finish_run("t5");
        check("t5_jumps", 32'(dut_jumps), 32'd4);
        check("t5_model_flushes", 32'(m_flushes), 32'd4);
        check("t5_r8", dut.Registers.register[8], 32'd4);
        check("t5_r9", dut.Registers.register[9], 32'd0);

        // Reset mid-run: pipeline clears at once, memory retained.
        clear_model();
        m_imem[0] = enc_i(6'h08, 5'd0, 5'd8, 16'd5);
        m_imem[1] = enc_i(6'h08, 5'd8, 5'd9, 16'd3);
        m_dmem[7] = 8'hA5;
        start_run();
        run_cycles(3);
        mon_en = 1'b0;
        rst = 1'b0;
        #1;
        check("t6_pc_async", dut.PC.pc_o, 32'd0);
        run_cycles(3);
        check("t6_pc_in_reset", dut.PC.pc_o, 32'd0);
        check("t6_r8_no_write", dut.Registers.register[8], 32'd0);
        check("t6_mem_kept", 32'(dut.Data_Memory.memory[7]), 32'h0000_00A5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/cpu.md
# cpu

Five-stage pipelined MIPS-subset processor (IF, ID, EX, MEM, WB) with on-chip instruction memory, data memory and register file. It is the top of the project; the bench loads programs and data through hierarchical references and observes architectural state the same way. EX-stage forwarding and load-use stalls are handled in hardware. Branches and jumps resolve in ID.

## Interface
- No parameters.
- clk_i  input  1  Clock; all state updates on the rising edge.
- rst_i  input  1  Asynchronous, active-low reset.
- start_i  input  1  Run enable; while 0 the PC holds its value.
- Fixed hierarchy, accessed directly by the bench:
  - PC.pc_o [31:0]
  - Instruction_Memory.memory[0:255] (32-bit words)
  - Data_Memory.memory[0:31] (8-bit bytes)
  - Registers.register[0:31] (32-bit)

## Operation
- Instruction set; any other encoding executes as a nop:
  - R-type, opcode 0: add funct 0x20, sub 0x22, and 0x24, or 0x25, mul 0x18. mul keeps the low 32 bits of the product.
  - addi 0x08, sign-extended immediate.
  - lw 0x23, sw 0x2B: address = rs + sext(imm).
  - beq 0x04.
  - j 0x02: target = {pc+4[31:28], imm26, 2'b00}.
- Instruction fetch: Instruction_Memory indexed by pc[9:2].
- Data memory:
  - Byte-addressed, little-endian, indexed by addr[4:0]; addresses wrap modulo 32.
  - Only aligned word accesses.
  - Reads are combinational; writes occur on the clock edge.
- Register file:
  - register[0] always reads 0; writes to it are ignored.
  - A write in WB is visible to an ID read in the same cycle (write-through bypass).
- Forwarding to EX ALU operands; priority EX/MEM over MEM/WB. Forwarding applies only when the destination is nonzero and RegWrite=1.
- Load-use hazard: an ID instruction reads rt or rs that matches the rt of a lw in EX. Response:
  - PC and IF/ID hold for one cycle.
  - A bubble (all control signals 0) is inserted into ID/EX.
- beq:
  - Compares register-file read values in ID.
  - If taken: pc ← pc+4 + (sext(imm)<<2), and IF/ID is flushed to a nop (1-cycle penalty).
  - No forwarding into ID. Software places at least 2 instructions between the producer and the beq.
- j: always flushes IF/ID (1-cycle penalty).
- When a stall and a branch/jump occur in the same cycle, the stall wins; the branch re-evaluates in the next cycle.
- Memories and the register file are not reset; the bench initializes them.

## Timing
- Reset (rst_i=0): PC=0, and all pipeline registers clear to nop/zero control, asynchronously.
- After rst_i=1 and start_i=1:
  - The first fetch is at PC=0.
  - pc_o increments by 4 on each rising edge that is not a stall.
- Latency:
  - An ALU instruction fetched in cycle n writes the register file at the edge ending cycle n+4.
  - A dependent instruction directly behind it executes without a stall.
- start_i dropping mid-run: PC holds while in-flight instructions continue to drain.
- Reset asserted mid-run: the pipeline clears immediately; memory contents are retained.

## Configuration
- CPU_MUL_EN:
  - Defined: mul (funct 0x18) is decoded and executed by a 32×32 multiplier in EX.
  - Undefined: the multiplier is omitted and mul behaves as a nop (no register write).

## Test plan
- Reset/start:
  - Stimulus: rst_i low, then high with start_i=1; instruction memory all zero.
  - Required: pc_o = 0, 4, 8, … one step per cycle; no state changes.
- Forwarding:
  - Program: addi $8,$0,5; addi $9,$8,3; add $10,$9,$8.
  - Required: $8=5, $9=8, $10=13, with no stalls.
- Load-use:
  - Setup: mem[0]=5. Program: lw $8,0($0); add $9,$8,$8.
  - Required: $9=10, exactly one stall cycle, PC held for one cycle.
- Store and multiply:
  - Program: addi $8,$0,6; addi $9,$0,7; mul $10,$8,$9; sw $10,4($0).
  - Required: word at 0x04 = 42. With CPU_MUL_EN undefined: $10 = 0 and word at 0x04 = 0.
- Branch/jump:
  - Program: a beq $0,$0,+1 (taken), followed by an addi $11,$0,1 in the delay position.
  - Required: $11 stays 0, and one flush occurs.
  - Program: a j back to a loop head.
  - Required: one flush per iteration, and pc_o shows the target address.
